// File: rtl/dec_ins.sv
// Decode/register-read stage: latches instruction fields, reads the GPR file
// and hands a stable operand bundle to execute over a valid/ready handshake.
//
// Ports:
//   clk, rst               stage clock, async active-low reset
//   inVld/inRdy            handshake with fetch (accept only in IDLE)
//   irOutOpe/irOutOth      opcode and instr[25:0] from fetch
//   npcIn                  PC+4 from fetch
//   wbEn/wbAddr/wbData     write-back port into the register file
//   outVld/outRdy          handshake with execute (bundle held in VALID)
//   opeOut..npcOut         latched operand bundle
module dec_ins #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inVld,
    output logic        inRdy,
    input  logic [5:0]  irOutOpe,
    input  logic [25:0] irOutOth,
    input  logic [31:0] npcIn,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic        outVld,
    input  logic        outRdy,
    output logic [5:0]  opeOut,
    output logic [4:0]  rsOut,
    output logic [4:0]  rtOut,
    output logic [4:0]  rdOut,
    output logic [4:0]  shamtOut,
    output logic [5:0]  functOut,
    output logic [31:0] regAOut,
    output logic [31:0] regBOut,
    output logic [31:0] immExtOut,
    output logic [31:0] jmpTgtOut,
    output logic [31:0] npcOut
);

    typedef enum logic [1:0] {IDLE, READ, VALID} state_t;

    state_t      state_q, state_d;
    logic [31:0] gpr_q [32];

    logic [5:0]  ope_q;
    logic [25:0] oth_q;
    logic [31:0] npc_q;
    logic [31:0] imm_q, imm_d;
    logic [31:0] jmp_q;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        accept;
    logic        wr_ok;
    logic [4:0]  rs_idx, rt_idx;

    assign accept = (state_q == IDLE) && inVld;
    assign wr_ok  = wbEn && (wbAddr != 5'd0);
    assign rs_idx = oth_q[25:21];
    assign rt_idx = oth_q[20:16];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inVld) state_d = READ;
            READ:    state_d = VALID;
            VALID:   if (outRdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        inRdy  = (state_q == IDLE);
        outVld = (state_q == VALID);
    end

    // Logical-immediate opcodes zero-extend, lui shifts up, rest sign-extend
    always_comb begin
        case (irOutOpe)
            6'h0C, 6'h0D, 6'h0E: imm_d = {16'h0000, irOutOth[15:0]};
            6'h0F:               imm_d = {irOutOth[15:0], 16'h0000};
            default:             imm_d = {{16{irOutOth[15]}}, irOutOth[15:0]};
        endcase
    end

    // Operand read with optional same-cycle write-back forwarding
    always_comb begin
        a_d = gpr_q[rs_idx];
        b_d = gpr_q[rt_idx];
        if (BYPASS_EN && wr_ok && (wbAddr == rs_idx)) a_d = wbData;
        if (BYPASS_EN && wr_ok && (wbAddr == rt_idx)) b_d = wbData;
    end

    // Register file; r0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (wr_ok) begin
            gpr_q[wbAddr] <= wbData;
        end
    end

    // Bundle registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ope_q <= '0;
            oth_q <= '0;
            npc_q <= '0;
            imm_q <= '0;
            jmp_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            if (accept) begin
                ope_q <= irOutOpe;
                oth_q <= irOutOth;
                npc_q <= npcIn;
                imm_q <= imm_d;
                jmp_q <= {npcIn[31:28], irOutOth, 2'b00};
            end
            if (state_q == READ) begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end
    end

    assign opeOut    = ope_q;
    assign rsOut     = oth_q[25:21];
    assign rtOut     = oth_q[20:16];
    assign rdOut     = oth_q[15:11];
    assign shamtOut  = oth_q[10:6];
    assign functOut  = oth_q[5:0];
    assign regAOut   = a_q;
    assign regBOut   = b_q;
    assign immExtOut = imm_q;
    assign jmpTgtOut = jmp_q;
    assign npcOut    = npc_q;

endmodule

// File: doc/dec_ins.md
# dec_ins

Decode/register-read stage of the multi-cycle CPU, directly downstream of the instruction-fetch stage. Consumes the 6-bit opcode, the 26-bit remaining instruction field and the next-PC produced by fetch. Holds the 32x32 architectural register file, extracts the instruction fields, reads rs/rt into latched A/B operands, and forms the extended immediate and jump target. Hands a stable operand bundle to the execute stage over a valid/ready handshake; the write-back stage writes the register file through a dedicated port.

## Interface
- BYPASS_EN, 1: when 1, a write-back in the READ cycle to rs/rt is forwarded into A/B; when 0, A/B take the pre-write value.
- clk  in  1  stage clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- inVld  in  1  fetch presents a valid instruction
- inRdy  out  1  stage can accept an instruction (high only in IDLE)
- irOutOpe  in  6  opcode, instr[31:26]
- irOutOth  in  26  instr[25:0]
- npcIn  in  32  PC+4 from fetch
- wbEn  in  1  register-file write enable
- wbAddr  in  5  write address
- wbData  in  32  write data
- outVld  out  1  operand bundle valid (high only in VALID)
- outRdy  in  1  execute stage accepts the bundle
- opeOut  out  6  latched opcode
- rsOut, rtOut, rdOut, shamtOut  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- functOut  out  6  instr[5:0]
- regAOut, regBOut  out  32 each  GPR[rs], GPR[rt]
- immExtOut  out  32  extended immediate
- jmpTgtOut  out  32  {npcIn[31:28], instr[25:0], 2'b00}
- npcOut  out  32  latched npcIn

## Operation
- FSM states: IDLE, READ, VALID. Reset state IDLE.
- IDLE: inRdy=1. If inVld, capture opcode, all fields, npcIn, immExtOut, jmpTgtOut into output registers; go READ. Else stay.
- READ: inRdy=0, outVld=0. Read GPR[rs], GPR[rt] into regAOut/regBOut; go VALID unconditionally.
- VALID: outVld=1. All outputs held stable. If outRdy, go IDLE; else stay.
- Immediate: opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori) zero-extend instr[15:0]; 0x0F (lui) gives {instr[15:0], 16'h0000}; every other opcode sign-extends instr[15:0].
- Register file: write on rising edge when wbEn=1 and wbAddr!=0, in any FSM state. Writes to r0 are discarded; reads of r0 always return 0.
- Bypass (BYPASS_EN=1): in READ, if wbEn=1, wbAddr!=0 and wbAddr==rs (resp. rt), regAOut (resp. regBOut) takes wbData. rs==rt==wbAddr forwards to both.
- Write-back during VALID that targets rs/rt does not alter latched A/B; the new value is visible to the next instruction.
- Reset assertion mid-operation: FSM to IDLE immediately, in-flight instruction dropped, all registers cleared.

## Timing
- Reset values: every output register and all 32 GPRs = 0; state IDLE, so inRdy=1, outVld=0 while rst is low and after release.
- Accept at edge N (IDLE, inVld=1) -> READ during cycle N+1 -> outVld=1 from edge N+2.
- Field outputs, immExtOut, jmpTgtOut and npcOut are valid from edge N+1; regAOut/regBOut from edge N+2.
- Transfer completes at the first edge with outVld=1 and outRdy=1; state is IDLE after that edge, so minimum issue interval is 3 cycles.
- inVld while not in IDLE is ignored; fetch must hold its outputs until inRdy.
- Register-file write latency 1 cycle: a write at edge M is readable by a READ cycle starting at or after edge M.

## Test plan
- Reset: drive rst low mid-VALID -> outVld=0, inRdy=1, all outputs 0; GPR reads return 0 afterward.
- Write r5=0xDEADBEEF, r6=0x00000010; issue add instr (rs=5, rt=6, rd=7, funct=0x20) -> outVld at N+2, regAOut=0xDEADBEEF, regBOut=0x10, rdOut=7, functOut=0x20.
- Immediate 0x8001: opcode 0x08 -> immExtOut=0xFFFF8001; 0x0D -> 0x00008001; 0x0F -> 0x80010000.
- Jump opcode 0x02, instr[25:0]=0x0000100, npcIn=0x40000004 -> jmpTgtOut=0x40000400.
- Bypass: wbEn=1, wbAddr=rs=rt=3, wbData=0x1234 during READ -> regAOut=regBOut=0x1234; repeat with BYPASS_EN=0 -> old value; write to r0 -> r0 reads 0.
- Backpressure: hold outRdy=0 for 5 cycles with inVld high and a write to rs -> outputs unchanged, inRdy=0; release outRdy -> IDLE next edge, next instruction accepted.
